// File: rtl/rx_frame_pkg.sv
// Shared types and helpers for the UART receive-side frame assembler.
package rx_frame_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_OPERAND,
        S_CMD,
        S_SETTLE,
        S_ISSUE
    } rx_frame_state_t;

    // Width of the operand byte index; a single-byte frame still needs one bit.
    function automatic int idx_width(input int num_bytes);
        return (num_bytes > 1) ? $clog2(num_bytes) : 1;
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte idle counter: flags the TIMEOUT_CYCLES-th consecutive idle
// cycle while a partial frame is outstanding.
module rx_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // An accepted byte in the final cycle suppresses expiry.
    assign expired = run && !clear && (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count idle cycles; restart on any byte, outside a partial frame, or on expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || !run || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// Collects NUM_OPS operands of OP_BYTES bytes (LSB first) plus a command byte
// from the UART byte stream and presents the frame with a valid/ready handshake.
// Optional inter-byte timeout is enabled by defining RX_FRAME_TIMEOUT_EN.
module rx_frame_assembler
    import rx_frame_pkg::*;
#(
    parameter int NUM_OPS        = 2,
    parameter int OP_BYTES       = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rx_ready,
    input  logic [BYTE_W-1:0]                   rx_data,
    output logic [NUM_OPS*OP_BYTES*BYTE_W-1:0]  operands,
    output logic [BYTE_W-1:0]                   cmd,
    output logic                                frame_valid,
    input  logic                                frame_ready,
    output logic                                busy,
    output logic                                overrun_err,
    output logic                                timeout_err
);

    localparam int NB = NUM_OPS * OP_BYTES;
    localparam int IW = idx_width(NB);

    rx_frame_state_t            state;
    logic [IW-1:0]              idx;
    logic [NB-1:0][BYTE_W-1:0]  lanes;
    logic [NB-1:0]              lane_we;
    logic                       last_idx;
    logic                       expired;

    assign last_idx = (idx == IW'(NB - 1));
    assign operands = lanes;

`ifdef RX_FRAME_TIMEOUT_EN
    logic accept;
    logic run;

    assign accept = rx_ready && (state == S_OPERAND || state == S_CMD);
    assign run    = (state == S_OPERAND && idx != '0) || (state == S_CMD);

    rx_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .run     (run),
        .expired (expired)
    );
`else
    // Parameter kept so both builds share one interface.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expired        = 1'b0;
`endif

    // Decode which byte lane the incoming operand byte lands in.
    always_comb begin
        lane_we = '0;
        for (int i = 0; i < NB; i++) begin
            lane_we[i] = (state == S_OPERAND) && rx_ready && (idx == IW'(i));
        end
    end

    // Byte-lane operand storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (lane_we[i]) lanes[i] <= rx_data;
            end
        end
    end

    // Frame sequencing FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_OPERAND;
            idx         <= '0;
            cmd         <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_OPERAND: begin
                    if (rx_ready) begin
                        busy <= 1'b1;
                        if (last_idx) begin
                            state <= S_CMD;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (expired) begin
                        idx         <= '0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (rx_ready) begin
                        cmd   <= rx_data;
                        state <= S_SETTLE;
                    end else if (expired) begin
                        state       <= S_OPERAND;
                        idx         <= '0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    overrun_err <= rx_ready;
                    state       <= S_ISSUE;
                    frame_valid <= 1'b1;
                end
                S_ISSUE: begin
                    overrun_err <= rx_ready;
                    if (frame_ready) begin
                        state       <= S_OPERAND;
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: state <= S_OPERAND;
            endcase
        end
    end

endmodule
